// File: rtl/ir_code_lock.sv
// IR keypad code lock: N-digit entry history, match/fail check, retry counting, lockout and timed unlock.
// Define IR_LOCK_ENTER_KEY_EN to require an explicit ENTER key before each check.
module ir_code_lock #(
   parameter int                      DIGITS         = 4,
   parameter int                      DIG_W          = 8,
   parameter logic [DIGITS*DIG_W-1:0] CODE           = 32'h01020304,
   parameter int                      MAX_TRIES      = 3,
   parameter int                      TIMEOUT_CYCLES = 250000000,
   parameter int                      OPEN_CYCLES    = 150000000,
   parameter int                      LOCKOUT_CYCLES = 1500000000,
   parameter logic [DIG_W-1:0]        ENTER_CODE     = 8'h16
) (
   input  logic                             iCLK,
   input  logic                             iRST,
   input  logic                             iDATA_READY,
   input  logic [DIG_W-1:0]                 iKEY,
   input  logic                             iCLEAR,
   output logic [DIGITS*DIG_W-1:0]          oDIGITS,
   output logic [$clog2(DIGITS+1)-1:0]      oCOUNT,
   output logic                             oMATCH,
   output logic                             oFAIL,
   output logic                             oUNLOCKED,
   output logic                             oLOCKOUT,
   output logic [$clog2(MAX_TRIES+1)-1:0]   oTRIES
);

`ifdef IR_LOCK_ENTER_KEY_EN
   localparam bit ENTER_EN = 1'b1;
`else
   localparam bit ENTER_EN = 1'b0;
`endif

   localparam int CW     = $clog2(DIGITS + 1);
   localparam int RW     = $clog2(MAX_TRIES + 1);
   localparam int T_MAX1 = (TIMEOUT_CYCLES > OPEN_CYCLES) ? TIMEOUT_CYCLES : OPEN_CYCLES;
   localparam int T_MAX  = (T_MAX1 > LOCKOUT_CYCLES) ? T_MAX1 : LOCKOUT_CYCLES;
   localparam int TW     = $clog2(T_MAX + 1);

   localparam logic [CW-1:0] FULL      = CW'(DIGITS);
   localparam logic [RW-1:0] TRIES_MAX = RW'(MAX_TRIES);
   localparam logic [TW-1:0] T_TIMEOUT = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] T_OPEN    = TW'(OPEN_CYCLES - 1);
   localparam logic [TW-1:0] T_LOCK    = TW'(LOCKOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ENTRY, S_CHECK, S_OPEN, S_FAIL, S_LOCKED
   } state_t;

   state_t                  state;
   logic                    rdy_q;
   logic [TW-1:0]           timer;
   logic [DIGITS*DIG_W-1:0] shifted;
   logic                    key_edge;
   logic                    enter_key;

   assign key_edge  = iDATA_READY & ~rdy_q;
   assign enter_key = ENTER_EN && (iKEY == ENTER_CODE);

   generate
      if (DIGITS == 1) begin : g_one
         assign shifted = iKEY;
      end else begin : g_many
         assign shifted = {oDIGITS[(DIGITS-1)*DIG_W-1:0], iKEY};
      end
   endgenerate

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state     <= S_IDLE;
         rdy_q     <= 1'b0;
         timer     <= '0;
         oDIGITS   <= '0;
         oCOUNT    <= '0;
         oMATCH    <= 1'b0;
         oFAIL     <= 1'b0;
         oUNLOCKED <= 1'b0;
         oLOCKOUT  <= 1'b0;
         oTRIES    <= '0;
      end else begin
         rdy_q  <= iDATA_READY;
         oMATCH <= 1'b0;
         oFAIL  <= 1'b0;
         case (state)
            S_IDLE, S_ENTRY: begin
               if (iCLEAR) begin
                  oDIGITS <= '0;
                  oCOUNT  <= '0;
                  timer   <= '0;
                  state   <= S_IDLE;
               end else if (key_edge) begin
                  timer <= '0;
                  // ENTER always goes through CHECK so a short entry fails with the usual latency
                  if (enter_key) begin
                     state <= S_CHECK;
                  end else begin
                     oDIGITS <= shifted;
                     if (oCOUNT != FULL)
                        oCOUNT <= oCOUNT + CW'(1);
                     if (!ENTER_EN && oCOUNT == FULL - CW'(1))
                        state <= S_CHECK;
                     else
                        state <= S_ENTRY;
                  end
               end else if (state == S_ENTRY) begin
                  if (timer == T_TIMEOUT) begin
                     oDIGITS <= '0;
                     oCOUNT  <= '0;
                     timer   <= '0;
                     state   <= S_IDLE;
                  end else begin
                     timer <= timer + TW'(1);
                  end
               end
            end
            S_CHECK: begin
               timer <= '0;
               if (oCOUNT == FULL && oDIGITS == CODE) begin
                  oMATCH    <= 1'b1;
                  oTRIES    <= '0;
                  oUNLOCKED <= 1'b1;
                  state     <= S_OPEN;
               end else begin
                  oFAIL  <= 1'b1;
                  oTRIES <= oTRIES + RW'(1);
                  state  <= S_FAIL;
               end
            end
            S_OPEN: begin
               if (iCLEAR || timer == T_OPEN) begin
                  oDIGITS   <= '0;
                  oCOUNT    <= '0;
                  oUNLOCKED <= 1'b0;
                  timer     <= '0;
                  state     <= S_IDLE;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            S_FAIL: begin
               oDIGITS <= '0;
               oCOUNT  <= '0;
               timer   <= '0;
               if (oTRIES == TRIES_MAX) begin
                  oLOCKOUT <= 1'b1;
                  state    <= S_LOCKED;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_LOCKED: begin
               if (timer == T_LOCK) begin
                  oLOCKOUT <= 1'b0;
                  oTRIES   <= '0;
                  timer    <= '0;
                  state    <= S_IDLE;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            default: begin
               state <= S_IDLE;
               timer <= '0;
            end
         endcase
      end
   end

endmodule
